// File: rtl/pcm_framer_if.sv
// Stream bundle for pcm_framer: strobed PCM input on one side,
// framed valid/ready output plus fill/overflow status on the other.
interface pcm_framer_if #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned BUF_DEPTH    = 1024
);
  logic [SAMPLE_WIDTH-1:0]    pcm_in;
  logic                       pcm_ready_i;
  logic [SAMPLE_WIDTH-1:0]    frame_data_o;
  logic                       frame_valid_o;
  logic                       frame_ready_i;
  logic                       frame_first_o;
  logic                       frame_last_o;
  logic [15:0]                frame_idx_o;
  logic [$clog2(BUF_DEPTH):0] fill_o;
  logic                       overflow_o;

  modport slave (
    input  pcm_in, pcm_ready_i, frame_ready_i,
    output frame_data_o, frame_valid_o, frame_first_o, frame_last_o,
           frame_idx_o, fill_o, overflow_o
  );

  modport master (
    output pcm_in, pcm_ready_i, frame_ready_i,
    input  frame_data_o, frame_valid_o, frame_first_o, frame_last_o,
           frame_idx_o, fill_o, overflow_o
  );
endinterface

// File: rtl/pcm_framer.sv
// Buffers strobed PCM samples in a circular RAM and replays them as
// overlapping FRAME_SIZE-sample frames advancing by FRAME_MOVE samples.
module pcm_framer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FRAME_SIZE   = 400,
  parameter int unsigned FRAME_MOVE   = 160,
  parameter int unsigned BUF_DEPTH    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  pcm_framer_if.slave bus
);
  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned IW = $clog2(FRAME_SIZE + 1);

  typedef enum logic [1:0] {IDLE, READ, STREAM} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SAMPLE_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [SAMPLE_WIDTH-1:0] r_rd_data;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_base;
  logic [IW-1:0]           r_rd_idx;
  logic [IW-1:0]           w_rd_idx_nxt;
  logic [FW-1:0]           r_fill;
  logic [15:0]             r_frame_idx;
  logic                    r_overflow;
  logic                    w_wr_en;
  logic                    w_hs;
  logic                    w_done;
  logic                    w_rd_en;
  logic [AW-1:0]           w_rd_addr;

  assign w_wr_en = bus.pcm_ready_i && (r_fill < FW'(BUF_DEPTH));
  assign w_hs    = (r_state == STREAM) && bus.frame_ready_i;
  assign w_done  = w_hs && (r_rd_idx == IW'(FRAME_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // In STREAM the RAM is re-read every cycle at the index that will be
  // current next cycle, so a stall re-reads the same word and a handshake
  // fetches the next one with no bubble.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_idx_nxt = r_rd_idx;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_base + AW'(r_rd_idx);
    case (r_state)
      IDLE: begin
        if (r_fill >= FW'(FRAME_SIZE)) begin
          w_state_nxt  = READ;
          w_rd_idx_nxt = '0;
        end
      end
      READ: begin
        w_rd_en     = 1'b1;
        w_state_nxt = STREAM;
      end
      STREAM: begin
        if (w_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_rd_en = 1'b1;
          if (w_hs) w_rd_idx_nxt = r_rd_idx + IW'(1);
          w_rd_addr = r_base + AW'(w_rd_idx_nxt);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) r_mem[r_wr_ptr] <= bus.pcm_in;
  end

  always_ff @(posedge clk) begin
    if (rst)          r_rd_data <= '0;
    else if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_base      <= '0;
      r_rd_idx    <= '0;
      r_fill      <= '0;
      r_frame_idx <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_rd_idx <= w_rd_idx_nxt;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (bus.pcm_ready_i && !w_wr_en) r_overflow <= 1'b1;
      r_fill <= r_fill + FW'(w_wr_en) - (w_done ? FW'(FRAME_MOVE) : '0);
      if (w_done) begin
        r_base      <= r_base + AW'(FRAME_MOVE);
        r_frame_idx <= r_frame_idx + 16'd1;
      end
    end
  end

  assign bus.frame_valid_o = (r_state == STREAM);
  assign bus.frame_first_o = (r_state == STREAM) && (r_rd_idx == '0);
  assign bus.frame_last_o  = (r_state == STREAM) && (r_rd_idx == IW'(FRAME_SIZE - 1));
  assign bus.frame_data_o  = r_rd_data;
  assign bus.frame_idx_o   = r_frame_idx;
  assign bus.fill_o        = r_fill;
  assign bus.overflow_o    = r_overflow;
endmodule

// File: tb/tb_pcm_framer.sv
// Self-checking bench for pcm_framer: a queue of accepted samples is the
// reference; frame k must replay entries [k*MOVE, k*MOVE+FS).
module tb_pcm_framer;
  localparam int SW   = 16;
  localparam int FS   = 400;
  localparam int MOVE = 160;
  localparam int BD   = 1024;
  localparam int FW   = $clog2(BD) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcm_framer_if #(.SAMPLE_WIDTH(SW), .BUF_DEPTH(BD)) bus();

  pcm_framer #(
    .SAMPLE_WIDTH(SW),
    .FRAME_SIZE  (FS),
    .FRAME_MOVE  (MOVE),
    .BUF_DEPTH   (BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [SW-1:0] q[$];
  int   m_fill, m_frame, m_pos;
  logic m_ovf;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic model_clear();
    q.delete();
    m_fill = 0; m_frame = 0; m_pos = 0; m_ovf = 1'b0;
  endtask

  // Drive inputs for the coming edge and advance the model accordingly.
  task automatic drive(input logic pv, input logic [SW-1:0] pd, input logic fr);
    logic hs;
    bus.pcm_ready_i   = pv;
    bus.pcm_in        = pd;
    bus.frame_ready_i = fr;
    hs = bus.frame_valid_o && fr;
    if (pv) begin
      if (m_fill < BD) begin q.push_back(pd); m_fill++; end
      else m_ovf = 1'b1;
    end
    if (hs) begin
      if (m_pos == FS - 1) begin m_pos = 0; m_frame++; m_fill -= MOVE; end
      else m_pos++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pcm_ready_i = 1'b0;
    bus.frame_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pcm_in        = SW'($urandom);
      bus.pcm_ready_i   = 1'($urandom);
      bus.frame_ready_i = 1'($urandom);
      @(negedge clk);
      n_total++;
      if (bus.frame_valid_o !== 1'b0 || bus.frame_data_o !== '0 || bus.frame_first_o !== 1'b0 ||
          bus.frame_last_o !== 1'b0 || bus.frame_idx_o !== '0 || bus.fill_o !== '0 || bus.overflow_o !== 1'b0)
        $display("FAIL reset cyc%0d: v=%b d=%h f=%b l=%b i=%0d fill=%0d ovf=%b want all 0", i,
                 bus.frame_valid_o, bus.frame_data_o, bus.frame_first_o, bus.frame_last_o,
                 bus.frame_idx_o, bus.fill_o, bus.overflow_o);
      else n_pass++;
    end
    rst = 1'b0;
    bus.pcm_ready_i = 1'b0;
    bus.frame_ready_i = 1'b0;
    model_clear();
  endtask

  task automatic test_first_frame();
    int rise_k = -1;
    int done_k = -1;
    for (int i = 0; i < FS; i++) begin
      @(negedge clk);
      n_total++;
      if (bus.fill_o !== FW'(m_fill) || bus.overflow_o !== m_ovf || bus.frame_valid_o !== 1'b0)
        $display("FAIL first_fill: got fill=%0d ovf=%b v=%b want %0d/%b/0", bus.fill_o, bus.overflow_o, bus.frame_valid_o, m_fill, m_ovf);
      else n_pass++;
      drive(1'b1, SW'(i), 1'b1);
    end
    for (int k = 1; k <= 600 && m_frame < 1; k++) begin
      @(negedge clk);
      if (bus.frame_valid_o && rise_k < 0) rise_k = k;
      n_total++;
      if (bus.fill_o !== FW'(m_fill) || bus.overflow_o !== m_ovf)
        $display("FAIL first_fill: got %0d/%b want %0d/%b", bus.fill_o, bus.overflow_o, m_fill, m_ovf);
      else n_pass++;
      if (bus.frame_valid_o) begin
        n_total++;
        if (bus.frame_data_o !== q[m_frame*MOVE + m_pos] || bus.frame_first_o !== (m_pos == 0) ||
            bus.frame_last_o !== (m_pos == FS - 1) || bus.frame_idx_o !== 16'(m_frame))
          $display("FAIL first_data pos %0d: got d=%0d f=%b l=%b i=%0d want d=%0d", m_pos,
                   bus.frame_data_o, bus.frame_first_o, bus.frame_last_o, bus.frame_idx_o, q[m_frame*MOVE + m_pos]);
        else n_pass++;
      end
      drive(1'b0, '0, 1'b1);
      if (m_frame == 1) done_k = k;
    end
    n_total++;
    if (rise_k !== 3) $display("FAIL first_latency: valid seen at cycle %0d want 3", rise_k);
    else n_pass++;
    n_total++;
    if (done_k - rise_k + 1 !== FS) $display("FAIL first_throughput: frame took %0d cycles want %0d", done_k - rise_k + 1, FS);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.fill_o !== FW'(240) || bus.frame_valid_o !== 1'b0)
      $display("FAIL first_after: got fill=%0d v=%b want 240/0", bus.fill_o, bus.frame_valid_o);
    else n_pass++;
    drive(1'b0, '0, 1'b1);
  endtask

  task automatic test_overlap();
    int nv = FS;
    for (int k = 0; k < 3000 && m_frame < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.fill_o !== FW'(m_fill) || bus.overflow_o !== m_ovf)
        $display("FAIL overlap_fill: got %0d/%b want %0d/%b", bus.fill_o, bus.overflow_o, m_fill, m_ovf);
      else n_pass++;
      if (bus.frame_valid_o) begin
        n_total++;
        if (q.size() < m_frame*MOVE + FS)
          $display("FAIL overlap_early frame %0d: only %0d samples written", m_frame, q.size());
        else if (bus.frame_data_o !== q[m_frame*MOVE + m_pos] || bus.frame_first_o !== (m_pos == 0) ||
                 bus.frame_last_o !== (m_pos == FS - 1) || bus.frame_idx_o !== 16'(m_frame))
          $display("FAIL overlap_data f%0d p%0d: got d=%0d f=%b l=%b i=%0d want d=%0d", m_frame, m_pos,
                   bus.frame_data_o, bus.frame_first_o, bus.frame_last_o, bus.frame_idx_o, q[m_frame*MOVE + m_pos]);
        else n_pass++;
      end
      drive(nv < 720, SW'(nv), 1'b1);
      if (nv < 720) nv++;
    end
    @(negedge clk);
    n_total++;
    if (m_frame !== 3 || bus.fill_o !== FW'(240))
      $display("FAIL overlap_end: frames=%0d fill=%0d want 3/240", m_frame, bus.fill_o);
    else n_pass++;
    drive(1'b0, '0, 1'b1);
  endtask

  task automatic test_random_stream();
    int nw = 0;
    do_reset();
    for (int t = 0; t < 20000 && (nw < 2000 || m_frame < 11); t++) begin
      logic pv;
      @(negedge clk);
      n_total++;
      if (bus.fill_o !== FW'(m_fill) || bus.overflow_o !== m_ovf)
        $display("FAIL rand_fill t%0d: got %0d/%b want %0d/%b", t, bus.fill_o, bus.overflow_o, m_fill, m_ovf);
      else n_pass++;
      if (bus.frame_valid_o) begin
        n_total++;
        if (q.size() < m_frame*MOVE + FS)
          $display("FAIL rand_early frame %0d: only %0d samples written", m_frame, q.size());
        else if (bus.frame_data_o !== q[m_frame*MOVE + m_pos] || bus.frame_first_o !== (m_pos == 0) ||
                 bus.frame_last_o !== (m_pos == FS - 1) || bus.frame_idx_o !== 16'(m_frame))
          $display("FAIL rand_data f%0d p%0d: got d=%h f=%b l=%b i=%0d want d=%h", m_frame, m_pos,
                   bus.frame_data_o, bus.frame_first_o, bus.frame_last_o, bus.frame_idx_o, q[m_frame*MOVE + m_pos]);
        else n_pass++;
      end
      pv = (t % 3 == 0) && (nw < 2000);
      drive(pv, SW'($urandom), $urandom_range(9, 0) < 7);
      if (pv) nw++;
    end
    n_total++;
    if (m_frame !== 11 || bus.overflow_o !== 1'b0)
      $display("FAIL rand_end: frames=%0d ovf=%b want 11/0", m_frame, bus.overflow_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int t = 0; t < 4000 && m_frame < 4; t++) begin
      @(negedge clk);
      n_total++;
      if (bus.fill_o !== FW'(m_fill) || bus.overflow_o !== m_ovf)
        $display("FAIL ovf_fill t%0d: got %0d/%b want %0d/%b", t, bus.fill_o, bus.overflow_o, m_fill, m_ovf);
      else n_pass++;
      if (bus.frame_valid_o) begin
        n_total++;
        if (q.size() < m_frame*MOVE + FS)
          $display("FAIL ovf_early frame %0d: only %0d samples held", m_frame, q.size());
        else if (bus.frame_data_o !== q[m_frame*MOVE + m_pos] || bus.frame_first_o !== (m_pos == 0) ||
                 bus.frame_last_o !== (m_pos == FS - 1) || bus.frame_idx_o !== 16'(m_frame))
          $display("FAIL ovf_data f%0d p%0d: got d=%0d f=%b l=%b i=%0d want d=%0d", m_frame, m_pos,
                   bus.frame_data_o, bus.frame_first_o, bus.frame_last_o, bus.frame_idx_o, q[m_frame*MOVE + m_pos]);
        else n_pass++;
      end
      if (t == 1030) begin
        n_total++;
        if (bus.fill_o !== FW'(BD) || bus.overflow_o !== 1'b1)
          $display("FAIL ovf_saturate: got fill=%0d ovf=%b want %0d/1", bus.fill_o, bus.overflow_o, BD);
        else n_pass++;
      end
      drive(t < 1030, SW'(t), t >= 1030);
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      n_total++;
      if (bus.frame_valid_o !== 1'b0 || bus.fill_o !== FW'(m_fill) || bus.overflow_o !== 1'b1)
        $display("FAIL ovf_tail: got v=%b fill=%0d ovf=%b want 0/%0d/1", bus.frame_valid_o, bus.fill_o, bus.overflow_o, m_fill);
      else n_pass++;
      drive(1'b0, '0, 1'b1);
    end
    n_total++;
    if (m_frame !== 4) $display("FAIL ovf_frames: got %0d want 4", m_frame);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    for (int t = 0; t < 3000 && !(m_frame == 5 && m_pos == 200); t++) begin
      @(negedge clk);
      n_total++;
      if (bus.fill_o !== FW'(m_fill) || bus.overflow_o !== m_ovf)
        $display("FAIL mid_fill t%0d: got %0d/%b want %0d/%b", t, bus.fill_o, bus.overflow_o, m_fill, m_ovf);
      else n_pass++;
      if (bus.frame_valid_o) begin
        n_total++;
        if (q.size() < m_frame*MOVE + FS)
          $display("FAIL mid_early frame %0d: only %0d samples", m_frame, q.size());
        else if (bus.frame_data_o !== q[m_frame*MOVE + m_pos] || bus.frame_idx_o !== 16'(m_frame))
          $display("FAIL mid_data f%0d p%0d: got d=%h i=%0d want d=%h", m_frame, m_pos,
                   bus.frame_data_o, bus.frame_idx_o, q[m_frame*MOVE + m_pos]);
        else n_pass++;
      end
      drive(1'b1, SW'($urandom), 1'b1);
    end
    @(negedge clk);
    n_total++;
    if (!(m_frame == 5 && m_pos == 200) || bus.frame_valid_o !== 1'b1)
      $display("FAIL mid_reach: frame=%0d pos=%0d v=%b want 5/200/1", m_frame, m_pos, bus.frame_valid_o);
    else n_pass++;
    rst = 1'b1;
    bus.pcm_ready_i = 1'b0;
    bus.frame_ready_i = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (bus.frame_valid_o !== 1'b0 || bus.fill_o !== '0 || bus.frame_idx_o !== '0 || bus.overflow_o !== 1'b0)
      $display("FAIL mid_reset: got v=%b fill=%0d i=%0d ovf=%b want all 0", bus.frame_valid_o, bus.fill_o, bus.frame_idx_o, bus.overflow_o);
    else n_pass++;
    drive(1'b0, '0, 1'b1);
    for (int t = 0; t < 2000 && m_frame < 1; t++) begin
      @(negedge clk);
      if (bus.frame_valid_o) begin
        n_total++;
        if (q.size() < FS)
          $display("FAIL fresh_early: only %0d samples", q.size());
        else if (bus.frame_data_o !== q[m_pos] || bus.frame_first_o !== (m_pos == 0) ||
                 bus.frame_last_o !== (m_pos == FS - 1) || bus.frame_idx_o !== 16'd0)
          $display("FAIL fresh_data p%0d: got d=%h f=%b l=%b i=%0d want d=%h", m_pos,
                   bus.frame_data_o, bus.frame_first_o, bus.frame_last_o, bus.frame_idx_o, q[m_pos]);
        else n_pass++;
      end
      drive(q.size() < FS, SW'($urandom), 1'b1);
    end
    n_total++;
    if (m_frame !== 1) $display("FAIL fresh_done: frames=%0d want 1", m_frame);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.pcm_in = '0;
    bus.pcm_ready_i = 1'b0;
    bus.frame_ready_i = 1'b0;
    model_clear();
    test_reset();
    test_first_frame();
    test_overlap();
    test_random_stream();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
